// File: rtl/mux4to1.sv
// Four-way WIDTH-bit selector. With MUX4TO1_REGISTERED_EN defined, the output is
// registered on clock_i with a synchronous clear on reset_i. Otherwise it is combinational.
module mux4to1 #(
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [1:0]       select_i,
    input  logic [WIDTH-1:0] input0_i,
    input  logic [WIDTH-1:0] input1_i,
    input  logic [WIDTH-1:0] input2_i,
    input  logic [WIDTH-1:0] input3_i,
    output logic [WIDTH-1:0] output_o
);

    logic [WIDTH-1:0] mux_out;

    // An unknown select falls to the X default; synthesis treats it as don't-care.
    always_comb begin
        mux_out = 'x;
        case (select_i)
            2'd0:    mux_out = input0_i;
            2'd1:    mux_out = input1_i;
            2'd2:    mux_out = input2_i;
            2'd3:    mux_out = input3_i;
            default: mux_out = 'x;
        endcase
    end

`ifdef MUX4TO1_REGISTERED_EN
    logic [WIDTH-1:0] output_d;
    logic [WIDTH-1:0] output_q;

    always_comb begin
        output_d = mux_out;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            output_q <= '0;
        end else begin
            output_q <= output_d;
        end
    end

    assign output_o = output_q;
`else
    // Clock and reset have no role in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clock_i ^ reset_i;

    assign output_o = mux_out;
`endif

endmodule

// File: tb/tb_mux4to1.sv
// Directed bench for mux4to1 at WIDTH 8, 1 and 64.
// It covers both the combinational build and the MUX4TO1_REGISTERED_EN build.
module tb_mux4to1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  sel;
    logic [7:0]  i0, i1, i2, i3;
    logic [7:0]  out8;
    logic [1:0]  sel_w;
    logic [0:0]  a0, a1, a2, a3, out1;
    logic [63:0] b0, b1, b2, b3, out64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux4to1 #(.WIDTH(8)) dut8 (
        .clock_i(clk), .reset_i(rst), .select_i(sel),
        .input0_i(i0), .input1_i(i1), .input2_i(i2), .input3_i(i3),
        .output_o(out8)
    );

    mux4to1 #(.WIDTH(1)) dut1 (
        .clock_i(clk), .reset_i(rst), .select_i(sel_w),
        .input0_i(a0), .input1_i(a1), .input2_i(a2), .input3_i(a3),
        .output_o(out1)
    );

    mux4to1 #(.WIDTH(64)) dut64 (
        .clock_i(clk), .reset_i(rst), .select_i(sel_w),
        .input0_i(b0), .input1_i(b1), .input2_i(b2), .input3_i(b3),
        .output_o(out64)
    );

    typedef struct {
        logic [1:0] sel;
        logic [7:0] i0, i1, i2, i3;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs, then wait one edge in the registered build or 1 ns otherwise.
    task automatic settle();
`ifdef MUX4TO1_REGISTERED_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic walk_wide();
        logic [63:0] w;
        logic [0:0]  n;
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 64; b++) begin
                @(negedge clk);
                w = 64'd1 << b;
                b0 = ~w; b1 = ~w; b2 = ~w; b3 = ~w;
                case (s)
                    0: b0 = w;
                    1: b1 = w;
                    2: b2 = w;
                    default: b3 = w;
                endcase
                n = (b % 2 == 0) ? 1'b1 : 1'b0;
                a0 = ~n; a1 = ~n; a2 = ~n; a3 = ~n;
                case (s)
                    0: a0 = n;
                    1: a1 = n;
                    2: a2 = n;
                    default: a3 = n;
                endcase
                sel_w = s[1:0];
                settle();
                check($sformatf("w64_s%0d_b%0d", s, b), out64, w);
                if (b < 2) check($sformatf("w1_s%0d_b%0d", s, b), {63'd0, out1}, {63'd0, n});
            end
        end
    endtask

    initial begin
        // Table rows 0-3 step the select, rows 4-7 hold select 2 while other inputs move,
        // and rows 8-11 use assorted patterns.
        tbl[0]  = '{2'd0, 8'h45, 8'h1a, 8'h6d, 8'h30, 8'h45};
        tbl[1]  = '{2'd1, 8'h45, 8'h1a, 8'h6d, 8'h30, 8'h1a};
        tbl[2]  = '{2'd2, 8'h45, 8'h1a, 8'h6d, 8'h30, 8'h6d};
        tbl[3]  = '{2'd3, 8'h45, 8'h1a, 8'h6d, 8'h30, 8'h30};
        tbl[4]  = '{2'd2, 8'hba, 8'h1a, 8'h6d, 8'h30, 8'h6d};
        tbl[5]  = '{2'd2, 8'hba, 8'he5, 8'h6d, 8'h30, 8'h6d};
        tbl[6]  = '{2'd2, 8'hba, 8'he5, 8'h6d, 8'hcf, 8'h6d};
        tbl[7]  = '{2'd2, 8'hba, 8'he5, 8'hff, 8'hcf, 8'hff};
        tbl[8]  = '{2'd0, 8'h80, 8'h01, 8'h00, 8'hff, 8'h80};
        tbl[9]  = '{2'd1, 8'h80, 8'h01, 8'h00, 8'hff, 8'h01};
        tbl[10] = '{2'd2, 8'h80, 8'h01, 8'h00, 8'hff, 8'h00};
        tbl[11] = '{2'd3, 8'h80, 8'h01, 8'h00, 8'hff, 8'hff};

        sel = 2'd0; i0 = 8'h45; i1 = 8'h1a; i2 = 8'h6d; i3 = 8'h30;
        sel_w = 2'd0;
        a0 = 1'b0; a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
        b0 = '0; b1 = '0; b2 = '0; b3 = '0;

`ifdef MUX4TO1_REGISTERED_EN
        // Hold reset for two edges. The output must be cleared even while data is present.
        @(negedge clk);
        rst = 1'b1; sel = 2'd3;
        @(posedge clk); #1;
        check("rst_edge1", {56'd0, out8}, 64'h00);
        @(posedge clk); #1;
        check("rst_edge2", {56'd0, out8}, 64'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_sel3", {56'd0, out8}, 64'h30);
        @(negedge clk);
        sel = 2'd0;
        #1;
        check("hold_between_edges", {56'd0, out8}, 64'h30);
        @(posedge clk); #1;
        check("step_sel0", {56'd0, out8}, 64'h45);
        @(negedge clk); sel = 2'd1;
        @(posedge clk); #1;
        check("step_sel1", {56'd0, out8}, 64'h1a);
        @(negedge clk); sel = 2'd2;
        @(posedge clk); #1;
        check("step_sel2", {56'd0, out8}, 64'h6d);
        // Pulse reset for one edge mid-run, then confirm the selected input is recaptured.
        @(negedge clk); sel = 2'd1;
        @(posedge clk); #1;
        check("pre_pulse", {56'd0, out8}, 64'h1a);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("pulse_clear", {56'd0, out8}, 64'h00);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("pulse_recover", {56'd0, out8}, 64'h1a);

        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sel = tbl[k].sel; i0 = tbl[k].i0; i1 = tbl[k].i1; i2 = tbl[k].i2; i3 = tbl[k].i3;
            @(posedge clk); #1;
            check($sformatf("vec%0d", k), {56'd0, out8}, {56'd0, tbl[k].exp});
        end
`else
        // In this build, reset must not affect the output.
        rst = 1'b1;
        #1;
        check("rst_ignored", {56'd0, out8}, 64'h45);
        rst = 1'b0;

        for (int k = 0; k < 12; k++) begin
            #9;
            sel = tbl[k].sel; i0 = tbl[k].i0; i1 = tbl[k].i1; i2 = tbl[k].i2; i3 = tbl[k].i3;
            #1;
            check($sformatf("vec%0d", k), {56'd0, out8}, {56'd0, tbl[k].exp});
        end

        // An unknown select must drive all-X. This is checked only where the simulator keeps X.
        i0 = 8'h45; i1 = 8'h1a; i2 = 8'h6d; i3 = 8'h30;
        sel = 2'bxx;
        #1;
        if ($isunknown(sel)) check("x_select", {56'd0, out8}, {56'd0, 8'hxx});
        sel = 2'd1;
        #1;
        check("x_recover", {56'd0, out8}, 64'h1a);
`endif

        walk_wide();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
